// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready handshakes.
// Single-cycle ADD/SUB/AND/ORR/PASS and an optional shift-add MUL.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid        request strobe; accepted when in_valid && in_ready
//   in_ready        high only in IDLE while rst is low
//   a_in, b_in      operands (WIDTH bits), captured at acceptance
//   alu_control     4-bit opcode (`ALU_ADD ... `ALU_MUL)
//   out_valid       result held while high, until out_ready
//   out_ready       consumer takes the result
//   alu_result      registered result
//   zero, negative, carry, overflow  registered Z/N/C/V flags
//
// Build option: define ALU_SEQ_MUL_EN to include the MUL_RUN state
// and the shift-add multiplier. Without it `ALU_MUL is treated as an
// unrecognised opcode (result 0, Z=1).

`ifndef WORD
`define WORD 64
`endif

`ifndef ALU_ADD
`define ALU_ADD 4'h0
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'h1
`endif
`ifndef ALU_AND
`define ALU_AND 4'h2
`endif
`ifndef ALU_ORR
`define ALU_ORR 4'h3
`endif
`ifndef ALU_PASS
`define ALU_PASS 4'h4
`endif
`ifndef ALU_MUL
`define ALU_MUL 4'h5
`endif

module alu_seq #(
    parameter int WIDTH = `WORD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow
);

    localparam int MSB = WIDTH - 1;

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        HOLD    = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd2
    } state_t;
`endif

    state_t state_q;
    state_t state_d;

    logic accept;
    logic load_alu;

    logic [WIDTH-1:0] alu_r;
    logic             alu_c;
    logic             alu_v;
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;

    // Single-cycle datapath, evaluated on the live inputs;
    // its value is only registered on the acceptance edge.
    assign add_w = {1'b0, a_in} + {1'b0, b_in};
    assign sub_w = {1'b0, a_in} - {1'b0, b_in};

    always_comb begin
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (alu_control)
            `ALU_ADD: begin
                alu_r = add_w[MSB:0];
                alu_c = add_w[WIDTH];
                alu_v = (a_in[MSB] == b_in[MSB]) &&
                        (add_w[MSB] != a_in[MSB]);
            end
            `ALU_SUB: begin
                alu_r = sub_w[MSB:0];
                // borrow out of the extended subtract is the top bit
                alu_c = ~sub_w[WIDTH];
                alu_v = (a_in[MSB] != b_in[MSB]) &&
                        (sub_w[MSB] != a_in[MSB]);
            end
            `ALU_AND:  alu_r = a_in & b_in;
            `ALU_ORR:  alu_r = a_in | b_in;
            `ALU_PASS: alu_r = b_in;
            default:   alu_r = '0;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = $clog2(WIDTH);

    logic             is_mul;
    logic             load_mul;
    logic             mul_step;
    logic             mul_done;
    logic             mul_last;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_step;
    logic [CW-1:0]    cnt_q;

    assign is_mul   = (alu_control == `ALU_MUL);
    assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign mul_last = (cnt_q == CW'(WIDTH - 1));

    // One multiplier bit per cycle: the multiplicand moves left,
    // the multiplier moves right, its LSB gates the add.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (load_mul) begin
            mcand_q  <= a_in;
            mplier_q <= b_in;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (mul_step) begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            acc_q    <= acc_step;
            cnt_q    <= cnt_q + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_alu = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        load_mul = 1'b0;
        mul_step = 1'b0;
        mul_done = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef ALU_SEQ_MUL_EN
                    if (is_mul) begin
                        state_d  = MUL_RUN;
                        load_mul = 1'b1;
                    end else begin
                        state_d  = HOLD;
                        load_alu = 1'b1;
                    end
`else
                    state_d  = HOLD;
                    load_alu = 1'b1;
`endif
                end
            end
`ifdef ALU_SEQ_MUL_EN
            MUL_RUN: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    state_d  = HOLD;
                    mul_done = 1'b1;
                end
            end
`endif
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result and flags only change on a load; HOLD keeps them
    // stable. Reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result <= '0;
            zero       <= 1'b0;
            negative   <= 1'b0;
            carry      <= 1'b0;
            overflow   <= 1'b0;
        end else if (load_alu) begin
            alu_result <= alu_r;
            zero       <= (alu_r == '0);
            negative   <= alu_r[MSB];
            carry      <= alu_c;
            overflow   <= alu_v;
`ifdef ALU_SEQ_MUL_EN
        end else if (mul_done) begin
            alu_result <= acc_step;
            zero       <= (acc_step == '0);
            negative   <= acc_step[MSB];
            carry      <= 1'b0;
            overflow   <= 1'b0;
`endif
        end
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default `WORD, operand/result width in bits (>= 8).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port a_in  input  WIDTH  operand A.
REQ-007 SHALL have port b_in  input  WIDTH  operand B.
REQ-008 SHALL have port alu_control  input  4  opcode: `ALU_ADD, `ALU_SUB, `ALU_AND, `ALU_ORR, `ALU_PASS, `ALU_MUL (new code, distinct from the others).
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port alu_result  output  WIDTH  registered result.
REQ-012 SHALL have port zero, negative, carry, overflow  output  1 each  registered flags (Z, N, C, V).

Function
REQ-013 SHALL implement an FSM with states IDLE, MUL_RUN and HOLD.
REQ-014 in_ready SHALL be 1 only in IDLE with rst low; a request is accepted when in_valid && in_ready.
REQ-015 On acceptance of ADD/SUB/AND/ORR/PASS, the FSM SHALL go to HOLD with result and flags registered, so out_valid rises the next cycle (latency 1).
REQ-016 ADD SHALL give a+b mod 2^WIDTH; C = carry out of bit WIDTH-1; V = signed overflow.
REQ-017 SUB SHALL give a-b mod 2^WIDTH; C = 1 when no borrow (a >= b unsigned); V = signed overflow.
REQ-018 AND, ORR and PASS (result = b) SHALL force C=0 and V=0.
REQ-019 For every opcode, Z SHALL equal (result == 0) and N SHALL equal result[WIDTH-1].
REQ-020 An unrecognised opcode SHALL complete in 1 cycle with result 0, Z=1, N=C=V=0.
REQ-021 On acceptance of MUL, the FSM SHALL enter MUL_RUN and perform shift-add, one multiplier bit per cycle, for exactly WIDTH cycles.
REQ-022 After those WIDTH cycles the FSM SHALL go to HOLD, so out_valid rises WIDTH+1 cycles after acceptance.
REQ-023 MUL result SHALL be the low WIDTH bits of the unsigned product, with C=V=0.
REQ-024 Operands and opcode SHALL be captured at acceptance; input changes during MUL_RUN or HOLD SHALL have no effect.
REQ-025 In HOLD, out_valid SHALL be 1 and result/flags SHALL be stable until out_ready=1; the FSM then returns to IDLE.
REQ-026 HOLD SHALL never accept a new request in the same cycle (maximum throughput one operation per 2 cycles).
REQ-027 out_valid SHALL be 0 in IDLE and MUL_RUN.

Reset
REQ-028 With rst high at a clock edge, the FSM SHALL go to IDLE, with out_valid=0, alu_result=0 and Z=N=C=V=0.
REQ-029 in_ready SHALL be 0 while rst is high.
REQ-030 Reset during MUL_RUN or HOLD SHALL abort the operation and discard its result.

Configuration
REQ-031 With macro ALU_SEQ_MUL_EN defined, MUL SHALL behave per REQ-021 to REQ-023.
REQ-032 Without ALU_SEQ_MUL_EN, the MUL_RUN state and multiplier datapath SHALL be omitted, and `ALU_MUL SHALL be handled as an unrecognised opcode per REQ-020.

Verification
REQ-033 ADD a=10, b=15 accepted at cycle 0 -> out_valid=1 at cycle 1, result 25, ZNCV=0000.
REQ-034 SUB a=10, b=15 -> result -5 (all ones except bit 2 = 0xFF..FB), N=1, Z=0, C=0, V=0; SUB 65536-65536 -> result 0, Z=1, C=1.
REQ-035 ADD a=2^(WIDTH-1)-1, b=1 -> result 2^(WIDTH-1), N=1, V=1, C=0; PASS a=256, b=0 -> result 0, Z=1.
REQ-036 MUL 65536*65536 with ALU_SEQ_MUL_EN, WIDTH=64 -> out_valid at cycle 65, result 2^32; out_ready held low 3 cycles -> result stable and in_ready=0 throughout. Without the macro -> out_valid at cycle 1, result 0, Z=1.
REQ-037 rst pulsed 1 cycle at cycle 10 of a MUL -> out_valid=0 afterward and no stale result, in_ready=1 the cycle after rst falls, then ORR 10|15 -> result 15.
